// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 refresh controller: state encodings,
// LCD command bytes and the nibble-to-ASCII translation.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_LINE1_ADDR,
        ST_LINE1_CHARS,
        ST_LINE2_ADDR,
        ST_LINE2_CHARS
    } lcd_state_e;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_SETUP,
        WR_EN,
        WR_HOLD,
        WR_WAIT
    } wr_phase_e;

    localparam logic [7:0] FUNC_SET = 8'h38;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] ENTRY    = 8'h06;
    localparam logic [7:0] LINE1    = 8'h80;
    localparam logic [7:0] LINE2    = 8'hC0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Raw nibbles become '0'..'9' / 'A'..'F'; everything else is already a glyph.
    function automatic logic [7:0] hex2ascii(input logic [7:0] b);
        logic [7:0] r;
        if (b < 8'h0A)
            r = b + 8'h30;
        else if (b < 8'h10)
            r = b + 8'h37;
        else
            r = b;
        return r;
    endfunction

endpackage

// File: rtl/lcd_write_cycle.sv
// One HD44780 bus write: latches RS/DATA on start, then setup, EN pulse, hold
// and the post-write wait, ending with a single-cycle done pulse.
module lcd_write_cycle
    import lcd_pkg::*;
#(
    parameter int T_SETUP = 4,
    parameter int T_EN    = 25,
    parameter int T_HOLD  = 4,
    parameter int T_CMD   = 2000,
    parameter int T_CLEAR = 82000,
    parameter int CNT_W   = 17
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       rs_i,
    input  logic [7:0] data_i,
    input  logic       long_wait_i,
    output logic       idle_o,
    output logic       done_o,
    output logic       lcd_rs_o,
    output logic [7:0] lcd_data_o,
    output logic       lcd_en_o
);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);
    // The idle cycle in which the next start is accepted is the last wait cycle.
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(T_CMD - 2);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(T_CLEAR - 2);

    wr_phase_e        phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             long_q, long_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             en_q;
    logic             done;
    logic             wait_single;
    logic [CNT_W-1:0] wait_last;

    assign wait_single = long_q ? (T_CLEAR == 1) : (T_CMD == 1);
    assign wait_last   = long_q ? CLEAR_LAST : CMD_LAST;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q + 1'b1;
        long_d  = long_q;
        rs_d    = rs_q;
        data_d  = data_q;
        done    = 1'b0;
        unique case (phase_q)
            WR_IDLE: begin
                cnt_d = '0;
                if (start_i) begin
                    phase_d = WR_SETUP;
                    rs_d    = rs_i;
                    data_d  = data_i;
                    long_d  = long_wait_i;
                end
            end
            WR_SETUP: if (cnt_q == SETUP_LAST) begin
                phase_d = WR_EN;
                cnt_d   = '0;
            end
            WR_EN: if (cnt_q == EN_LAST) begin
                phase_d = WR_HOLD;
                cnt_d   = '0;
            end
            WR_HOLD: if (cnt_q == HOLD_LAST) begin
                cnt_d = '0;
                if (wait_single) begin
                    phase_d = WR_IDLE;
                    done    = 1'b1;
                end else begin
                    phase_d = WR_WAIT;
                end
            end
            WR_WAIT: if (cnt_q == wait_last) begin
                phase_d = WR_IDLE;
                cnt_d   = '0;
                done    = 1'b1;
            end
            default: phase_d = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= WR_IDLE;
            cnt_q   <= '0;
            long_q  <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            en_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            long_q  <= long_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            en_q    <= (phase_d == WR_EN);
        end
    end

    assign idle_o     = (phase_q == WR_IDLE);
    assign done_o     = done;
    assign lcd_rs_o   = rs_q;
    assign lcd_data_o = data_q;
    assign lcd_en_o   = en_q;

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// DE2-115 16x2 character LCD driver: power-up wait, init commands, then an
// endless scan of character positions 0..31 from a combinational source.
module lcd_refresh_ctrl
    import lcd_pkg::*;
#(
    parameter int T_PWRUP = 1000000,
    parameter int T_SETUP = 4,
    parameter int T_EN    = 25,
    parameter int T_HOLD  = 4,
    parameter int T_CMD   = 2000,
    parameter int T_CLEAR = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] lcd_index,
    input  logic [7:0] lcd_char,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_ON,
    output logic       init_done
);

    localparam int T_MAX = max_int(max_int(max_int(T_PWRUP, T_SETUP), max_int(T_EN, T_HOLD)),
                                   max_int(T_CMD, T_CLEAR));
    localparam int CNT_W = $clog2(T_MAX + 1);
    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(T_PWRUP - 1);

    lcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] pwr_cnt_q, pwr_cnt_d;
    logic [2:0]       step_q, step_d;
    logic [4:0]       idx_q, idx_d;
    logic             init_done_q, init_done_d;
    logic             start, wr_rs, wr_long, wr_idle, wr_done;
    logic [7:0]       wr_data;

    // A new write is offered whenever the write engine is idle; lcd_index was
    // settled at the previous done edge, so lcd_char is valid in this cycle.
    always_comb begin
        state_d     = state_q;
        pwr_cnt_d   = pwr_cnt_q;
        step_d      = step_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        start       = wr_idle && (state_q != ST_PWRUP);
        wr_rs       = 1'b0;
        wr_long     = 1'b0;
        wr_data     = FUNC_SET;
        unique case (state_q)
            ST_PWRUP: begin
                pwr_cnt_d = pwr_cnt_q + 1'b1;
                if (pwr_cnt_q == PWR_LAST) state_d = ST_INIT;
            end
            ST_INIT: begin
                unique case (step_q)
                    3'd0, 3'd1: wr_data = FUNC_SET;
                    3'd2:       wr_data = DISP_ON;
                    3'd3: begin
                        wr_data = CLEAR;
                        wr_long = 1'b1;
                    end
                    default:    wr_data = ENTRY;
                endcase
                if (wr_done) begin
                    if (step_q == 3'd4) begin
                        state_d     = ST_LINE1_ADDR;
                        init_done_d = 1'b1;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            ST_LINE1_ADDR: begin
                wr_data = LINE1;
                if (wr_done) begin
                    state_d = ST_LINE1_CHARS;
                    idx_d   = 5'd0;
                end
            end
            ST_LINE1_CHARS: begin
                wr_rs   = 1'b1;
                wr_data = hex2ascii(lcd_char);
                if (wr_done) begin
                    if (idx_q == 5'd15) state_d = ST_LINE2_ADDR;
                    else                idx_d   = idx_q + 5'd1;
                end
            end
            ST_LINE2_ADDR: begin
                wr_data = LINE2;
                if (wr_done) begin
                    state_d = ST_LINE2_CHARS;
                    idx_d   = 5'd16;
                end
            end
            ST_LINE2_CHARS: begin
                wr_rs   = 1'b1;
                wr_data = hex2ascii(lcd_char);
                if (wr_done) begin
                    if (idx_q == 5'd31) state_d = ST_LINE1_ADDR;
                    else                idx_d   = idx_q + 5'd1;
                end
            end
            default: state_d = ST_PWRUP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PWRUP;
            pwr_cnt_q   <= '0;
            step_q      <= 3'd0;
            idx_q       <= 5'd0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pwr_cnt_q   <= pwr_cnt_d;
            step_q      <= step_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
        end
    end

    lcd_write_cycle #(
        .T_SETUP (T_SETUP),
        .T_EN    (T_EN),
        .T_HOLD  (T_HOLD),
        .T_CMD   (T_CMD),
        .T_CLEAR (T_CLEAR),
        .CNT_W   (CNT_W)
    ) u_write (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .rs_i        (wr_rs),
        .data_i      (wr_data),
        .long_wait_i (wr_long),
        .idle_o      (wr_idle),
        .done_o      (wr_done),
        .lcd_rs_o    (LCD_RS),
        .lcd_data_o  (LCD_DATA),
        .lcd_en_o    (LCD_EN)
    );

    assign lcd_index = {3'b000, idx_q};
    assign init_done = init_done_q;
    assign LCD_RW    = 1'b0;
    assign LCD_ON    = 1'b1;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Scoreboard bench for lcd_refresh_ctrl: expected LCD writes are queued from a
// list-level model and checked by a monitor on every EN pulse.
module tb_lcd_refresh_ctrl;

    localparam int T_PWRUP = 10;
    localparam int T_SETUP = 2;
    localparam int T_EN    = 3;
    localparam int T_HOLD  = 2;
    localparam int T_CMD   = 5;
    localparam int T_CLEAR = 8;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         idx;
        bit         long_w;
        bit         done_exp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] lcd_index;
    logic [7:0] lcd_char;
    logic [7:0] LCD_DATA;
    logic       LCD_RS, LCD_RW, LCD_EN, LCD_ON, init_done;

    logic [7:0] tbl [4][32];
    logic [1:0] src_frame;
    logic       ovr_en;
    logic [7:0] ovr_val;

    exp_t q[$];
    int compared = 0;
    int failed   = 0;

    // Character source: a per-frame table indexed by lcd_index, with an
    // override used to disturb lcd_char while a write is in progress.
    assign lcd_char = ovr_en ? ovr_val : tbl[src_frame][lcd_index[4:0]];

    lcd_refresh_ctrl #(
        .T_PWRUP (T_PWRUP),
        .T_SETUP (T_SETUP),
        .T_EN    (T_EN),
        .T_HOLD  (T_HOLD),
        .T_CMD   (T_CMD),
        .T_CLEAR (T_CLEAR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lcd_index (lcd_index),
        .lcd_char  (lcd_char),
        .LCD_DATA  (LCD_DATA),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .LCD_EN    (LCD_EN),
        .LCD_ON    (LCD_ON),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] to_lcd(input logic [7:0] c);
        if (c <= 8'h09) return 8'h30 + c;
        if (c <= 8'h0F) return 8'h41 + (c - 8'h0A);
        return c;
    endfunction

    task automatic push(input logic rs, input logic [7:0] d, input int idx,
                        input bit lw, input bit de);
        exp_t e;
        e.rs = rs; e.data = d; e.idx = idx; e.long_w = lw; e.done_exp = de;
        q.push_back(e);
    endtask

    task automatic push_init();
        push(1'b0, 8'h38, -1, 1'b0, 1'b0);
        push(1'b0, 8'h38, -1, 1'b0, 1'b0);
        push(1'b0, 8'h0C, -1, 1'b0, 1'b0);
        push(1'b0, 8'h01, -1, 1'b1, 1'b0);
        push(1'b0, 8'h06, -1, 1'b0, 1'b0);
    endtask

    task automatic push_frame(input int f);
        push(1'b0, 8'h80, -1, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) push(1'b1, to_lcd(tbl[f][i]), i, 1'b0, 1'b1);
        push(1'b0, 8'hC0, -1, 1'b0, 1'b1);
        for (int i = 16; i < 32; i++) push(1'b1, to_lcd(tbl[f][i]), i, 1'b0, 1'b1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_en"},        32'(LCD_EN),    32'd0);
        chk({tag, "_index"},     32'(lcd_index), 32'd0);
        chk({tag, "_data"},      32'(LCD_DATA),  32'd0);
        chk({tag, "_rs"},        32'(LCD_RS),    32'd0);
        chk({tag, "_init_done"}, 32'(init_done), 32'd0);
        chk({tag, "_rw"},        32'(LCD_RW),    32'd0);
        chk({tag, "_on"},        32'(LCD_ON),    32'd1);
    endtask

    // Runs the source model (frame switch on wrap, mid-EN disturbance) until
    // every queued write has been seen, or the cycle budget runs out.
    task automatic run_until_empty(input int budget, input string tag);
        int   n = 0;
        logic [7:0] prev_idx = lcd_index;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
            if (prev_idx == 8'd31 && lcd_index == 8'd0) src_frame = src_frame + 2'd1;
            prev_idx = lcd_index;
            if (LCD_EN && LCD_RS && $urandom_range(0, 2) == 0) begin
                ovr_en  = 1'b1;
                ovr_val = 8'($urandom);
            end else if (!LCD_EN) begin
                ovr_en = 1'b0;
            end
        end
        chk({tag, "_pending_writes"}, 32'(q.size()), 32'd0);
    endtask

    // Monitor
    int         edge_cnt;
    int         rise_edge, fall_edge, last_wait;
    bit         first_rise, prev_en;
    exp_t       cur;
    logic [7:0] cap_data, cap_idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= -1;
        else        edge_cnt <= edge_cnt + 1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en    = 1'b0;
            first_rise = 1'b0;
        end else begin
            if (LCD_EN && !prev_en) begin
                if (!first_rise)
                    chk("first_en_rise_cycle", 32'(edge_cnt), 32'(T_PWRUP + T_SETUP));
                else
                    chk("fall_to_rise_gap", 32'(edge_cnt - fall_edge),
                        32'(T_HOLD + last_wait + T_SETUP));
                first_rise = 1'b1;
                rise_edge  = edge_cnt;
                if (q.size() == 0) begin
                    chk("unexpected_write", 32'(LCD_DATA), 32'hFFFF_FFFF);
                    cur.rs = LCD_RS; cur.data = LCD_DATA; cur.idx = -1;
                    cur.long_w = 1'b0; cur.done_exp = init_done;
                end else begin
                    cur = q.pop_front();
                    chk("write_rs",   32'(LCD_RS),    32'(cur.rs));
                    chk("write_data", 32'(LCD_DATA),  32'(cur.data));
                    chk("init_done",  32'(init_done), 32'(cur.done_exp));
                    chk("lcd_rw",     32'(LCD_RW),    32'd0);
                    if (cur.idx >= 0) chk("write_index", 32'(lcd_index), 32'(cur.idx));
                end
                cap_data = LCD_DATA;
                cap_idx  = lcd_index;
            end
            if (!LCD_EN && prev_en) begin
                chk("en_width",         32'(edge_cnt - rise_edge), 32'(T_EN));
                chk("data_stable",      32'(LCD_DATA),  32'(cap_data));
                chk("rs_stable",        32'(LCD_RS),    32'(cur.rs));
                chk("index_stable",     32'(lcd_index), 32'(cap_idx));
                fall_edge = edge_cnt;
                last_wait = cur.long_w ? T_CLEAR : T_CMD;
            end
            prev_en = LCD_EN;
        end
    end

    initial begin
        rst_n     = 1'b0;
        ovr_en    = 1'b0;
        ovr_val   = 8'h00;
        src_frame = 2'd0;
        for (int i = 0; i < 32; i++) begin
            tbl[0][i] = 8'h41 + 8'(i);
            tbl[1][i] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            tbl[2][i] = 8'($urandom_range(0, 31));
            tbl[3][i] = 8'($urandom);
        end
        tbl[1][5] = 8'h0B;
        tbl[1][6] = 8'h07;
        tbl[1][7] = 8'h7A;
        tbl[2][0] = 8'h00;
        tbl[2][1] = 8'h09;
        tbl[2][2] = 8'h0A;
        tbl[2][3] = 8'h0F;
        tbl[2][4] = 8'h10;

        push_init();
        for (int f = 0; f < 3; f++) push_frame(f);
        push(1'b0, 8'h80, -1, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        #1 check_reset("por");
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_until_empty(4000, "run1");

        // Asynchronous reset in the middle of an EN pulse.
        #2 rst_n = 1'b0;
        #1 check_reset("midwrite_reset");
        ovr_en    = 1'b0;
        src_frame = 2'd0;
        q.delete();
        push_init();
        push_frame(0);
        push(1'b0, 8'h80, -1, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_until_empty(2000, "run2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
